// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing the 16-bit accumulator multicycle datapath.
// Optional feature macro CTRL_HALT_EN: Op 1111 enters a sticky HALT state (otherwise it decodes as illegal).
module multicycle_ctrl #(
   parameter int OP_W   = 4,
   parameter int FUNC_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   Op,
   input  logic [FUNC_W-1:0] Func,
   input  logic              Zero,
   output logic              AdrSrc,
   output logic              MemWrite,
   output logic              IRWrite,
   output logic              RegWrite,
   output logic              A3Src,
   output logic              PCWrite,
   output logic              OldPCWrite,
   output logic              MDRWrite,
   output logic              ResultSrc,
   output logic [1:0]        ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [1:0]        ImmSrc,
   output logic [1:0]        PCSrc,
   output logic [2:0]        ALUControl,
   output logic              illegal,
   output logic              halted
);

   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(4'b0000);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(4'b0001);
   localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(4'b0010);
   localparam logic [OP_W-1:0] OP_BRZ   = OP_W'(4'b0100);
   localparam logic [OP_W-1:0] OP_ALUR  = OP_W'(4'b1000);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(4'b1100);
   localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(4'b1101);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(4'b1110);
   localparam logic [OP_W-1:0] OP_HLT   = OP_W'(4'b1111);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_JUMP, S_BRANCH
`ifdef CTRL_HALT_EN
      , S_HALT
`endif
   } state_t;

   typedef enum logic [3:0] {
      C_NOP, C_ILL, C_LOAD, C_STORE, C_JUMP, C_BRZ, C_ALUR, C_IMM, C_HLT
   } cls_t;

   typedef struct packed {
      cls_t       cls;
      logic [2:0] aop;
      logic [1:0] imm;
      logic       mto;
   } dec_t;

   typedef struct packed {
      logic       adr_src, mem_write, ir_write, reg_write, a3_src;
      logic       pc_write, old_pc_write, mdr_write, result_src, branch;
      logic [1:0] src_a, src_b, imm_src, pc_src;
      logic [2:0] alu_ctl;
   } ctrl_t;

   function automatic dec_t decode(logic [OP_W-1:0] op, logic [FUNC_W-1:0] fn);
      dec_t d;
      d = '{cls: C_ILL, aop: 3'b000, imm: 2'b00, mto: 1'b0};
      case (op)
         OP_LOAD:  d.cls = C_LOAD;
         OP_STORE: d.cls = C_STORE;
         OP_JUMP:  d.cls = C_JUMP;
         OP_BRZ:   d.cls = C_BRZ;
         OP_ADDI:  begin d.cls = C_IMM; d.aop = 3'b000; d.imm = 2'b01; end
         OP_SUBI:  begin d.cls = C_IMM; d.aop = 3'b001; d.imm = 2'b01; end
         OP_ANDI:  begin d.cls = C_IMM; d.aop = 3'b010; d.imm = 2'b00; end
`ifdef CTRL_HALT_EN
         OP_HLT:   d.cls = C_HLT;
`else
         OP_HLT:   d.cls = C_ILL;
`endif
         OP_ALUR: begin
            // Func must be strictly one-hot in [7:0]; anything else stays illegal
            if (!fn[8] && $onehot(fn[7:0])) begin
               d.cls = C_ALUR;
               case (1'b1)
                  fn[0]:   begin d.aop = 3'b101; d.mto = 1'b1; end
                  fn[1]:   d.aop = 3'b110;
                  fn[2]:   d.aop = 3'b000;
                  fn[3]:   d.aop = 3'b001;
                  fn[4]:   d.aop = 3'b010;
                  fn[5]:   d.aop = 3'b011;
                  fn[6]:   d.aop = 3'b100;
                  default: d.cls = C_NOP;
               endcase
            end
         end
         default: d.cls = C_ILL;
      endcase
      return d;
   endfunction

   function automatic ctrl_t ctrl_for(state_t s, dec_t d);
      ctrl_t o;
      o = '0;
      case (s)
         S_FETCH:    begin o.ir_write = 1'b1; o.old_pc_write = 1'b1; o.pc_write = 1'b1;
                           o.src_b = 2'b01; o.alu_ctl = 3'b000; end
         S_MEMADR:   begin o.src_b = 2'b10; o.alu_ctl = 3'b110; end
         S_MEMREAD:  begin o.adr_src = 1'b1; o.mdr_write = 1'b1; end
         S_MEMWB:    begin o.reg_write = 1'b1; o.result_src = 1'b1; end
         S_MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
         S_EXECR:    begin o.src_a = 2'b10; o.src_b = 2'b00; o.alu_ctl = d.aop; end
         S_EXECI:    begin o.src_a = 2'b10; o.src_b = 2'b10; o.imm_src = d.imm; o.alu_ctl = d.aop; end
         S_ALUWB:    begin o.reg_write = 1'b1; o.a3_src = d.mto; end
         S_JUMP:     begin o.pc_write = 1'b1; o.pc_src = 2'b01; end
         S_BRANCH:   begin o.src_a = 2'b10; o.alu_ctl = 3'b001; o.pc_src = 2'b10; o.branch = 1'b1; end
         default:    o = '0;
      endcase
      return o;
   endfunction

   localparam dec_t DEC_RST = '{cls: C_NOP, aop: 3'b000, imm: 2'b00, mto: 1'b0};

   state_t state_q, state_d;
   dec_t   dec, dq_q, dq_d;
   ctrl_t  outs_q;

   always_comb begin
      dec     = decode(Op, Func);
      state_d = state_q;
      dq_d    = dq_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            dq_d = dec;
            case (dec.cls)
               C_LOAD, C_STORE: state_d = S_MEMADR;
               C_JUMP:          state_d = S_JUMP;
               C_BRZ:           state_d = S_BRANCH;
               C_ALUR:          state_d = S_EXECR;
               C_IMM:           state_d = S_EXECI;
`ifdef CTRL_HALT_EN
               C_HLT:           state_d = S_HALT;
`endif
               default:         state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (dq_q.cls == C_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
`ifdef CTRL_HALT_EN
         S_HALT:     state_d = S_HALT;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state; the reset value is the FETCH word,
   // so the first cycle after release already drives FETCH while reset masks it below.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         dq_q    <= DEC_RST;
         outs_q  <= ctrl_for(S_FETCH, DEC_RST);
      end else begin
         state_q <= state_d;
         dq_q    <= dq_d;
         outs_q  <= ctrl_for(state_d, dq_d);
      end
   end

   assign AdrSrc     = reset & outs_q.adr_src;
   assign MemWrite   = reset & outs_q.mem_write;
   assign IRWrite    = reset & outs_q.ir_write;
   assign RegWrite   = reset & outs_q.reg_write;
   assign A3Src      = reset & outs_q.a3_src;
   assign PCWrite    = reset & (outs_q.pc_write | (outs_q.branch & Zero));
   assign OldPCWrite = reset & outs_q.old_pc_write;
   assign MDRWrite   = reset & outs_q.mdr_write;
   assign ResultSrc  = reset & outs_q.result_src;
   assign ALUSrcA    = {2{reset}} & outs_q.src_a;
   assign ALUSrcB    = {2{reset}} & outs_q.src_b;
   assign ImmSrc     = {2{reset}} & outs_q.imm_src;
   assign PCSrc      = {2{reset}} & outs_q.pc_src;
   assign ALUControl = {3{reset}} & outs_q.alu_ctl;
   // IR is loaded at the FETCH edge, so the opcode is only visible during DECODE itself
   assign illegal    = reset & (state_q == S_DECODE) & (dec.cls == C_ILL);
`ifdef CTRL_HALT_EN
   assign halted     = reset & (state_q == S_HALT);
`else
   assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues instructions and queues the
// expected control word for every cycle; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

   logic       clk, reset, Zero;
   logic [3:0] Op;
   logic [8:0] Func;
   logic       AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite, ResultSrc;
   logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, PCSrc;
   logic [2:0] ALUControl;
   logic       illegal, halted;

   typedef struct packed {
      logic       adr_src, mem_write, ir_write, reg_write, a3_src;
      logic       pc_write, old_pc_write, mdr_write, result_src;
      logic [1:0] src_a, src_b, imm_src, pc_src;
      logic [2:0] alu_ctl;
      logic       ill, hlt;
   } cv_t;

`ifdef CTRL_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   cv_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   bit  mon_en  = 1'b0;

   multicycle_ctrl #(.OP_W(4), .FUNC_W(9)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .A3Src(A3Src), .PCWrite(PCWrite), .OldPCWrite(OldPCWrite), .MDRWrite(MDRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .PCSrc(PCSrc), .ALUControl(ALUControl), .illegal(illegal), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: ALU-R function field -> ALU operation, or -1 for NOP, -2 for illegal
   function automatic int alur_op(logic [8:0] f);
      if (f[8] || $countones(f) != 1) return -2;
      if (f[7]) return -1;
      for (int i = 0; i < 7; i++)
         if (f[i]) return (i == 0) ? 5 : (i == 1) ? 6 : i - 2;
      return -2;
   endfunction

   function automatic bit is_illegal(logic [3:0] op, logic [8:0] f);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd13, 4'd14: return 1'b0;
         4'd8:  return alur_op(f) == -2;
         4'd15: return !HALT_EN;
         default: return 1'b1;
      endcase
   endfunction

   function automatic int cpi(logic [3:0] op, logic [8:0] f);
      if (is_illegal(op, f)) return 2;
      case (op)
         4'd0: return 5;
         4'd1, 4'd12, 4'd13, 4'd14: return 4;
         4'd2, 4'd4: return 3;
         4'd8: return (alur_op(f) == -1) ? 2 : 4;
         default: return 2;
      endcase
   endfunction

   function automatic cv_t expect_cycle(logic [3:0] op, logic [8:0] f, int k, logic z);
      cv_t e;
      int  a;
      e = '0;
      if (k == 0) begin
         e.ir_write = 1; e.old_pc_write = 1; e.pc_write = 1; e.src_b = 2'b01; e.alu_ctl = 3'd0;
         return e;
      end
      if (k == 1) begin
         e.ill = is_illegal(op, f);
         return e;
      end
      a = alur_op(f);
      case (op)
         4'd0, 4'd1: begin
            if (k == 2) begin e.src_b = 2'b10; e.alu_ctl = 3'd6; end
            else if (op == 4'd0 && k == 3) begin e.adr_src = 1; e.mdr_write = 1; end
            else if (op == 4'd0 && k == 4) begin e.reg_write = 1; e.result_src = 1; end
            else if (op == 4'd1 && k == 3) begin e.adr_src = 1; e.mem_write = 1; end
         end
         4'd2: begin e.pc_write = 1; e.pc_src = 2'b01; end
         4'd4: begin e.src_a = 2'b10; e.alu_ctl = 3'd1; e.pc_src = 2'b10; e.pc_write = z; end
         4'd8: begin
            if (k == 2) begin e.src_a = 2'b10; e.alu_ctl = 3'(a); end
            else begin e.reg_write = 1; e.a3_src = (a == 5); end
         end
         4'd12, 4'd13, 4'd14: begin
            if (k == 2) begin
               e.src_a = 2'b10; e.src_b = 2'b10;
               e.imm_src = (op == 4'd14) ? 2'b00 : 2'b01;
               e.alu_ctl = 3'(op - 4'd12);
            end else e.reg_write = 1;
         end
         4'd15: e.hlt = 1;
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic do_reset(int n);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         Op = 4'($urandom); Func = 9'($urandom); Zero = 1'($urandom);
         sb.push_back(cv_t'(0));
         @(posedge clk); #1;
      end
      reset = 1'b1;
   endtask

   // zmode: 0 random Zero each cycle, 1 force Zero=1, 2 force Zero=0
   task automatic run_instr(logic [3:0] op, logic [8:0] f, int zmode, bit allow_abort, int nhalt);
      int  n;
      bit  hlt;
      hlt = (op == 4'd15) && HALT_EN;
      n = hlt ? 2 + nhalt : cpi(op, f);
      for (int k = 0; k < n; k++) begin
         if (allow_abort && k > 0 && $urandom_range(0, 39) == 0) begin
            do_reset($urandom_range(1, 2));
            return;
         end
         if (k == 1) begin Op = op; Func = f; end
         else begin Op = 4'($urandom); Func = 9'($urandom); end
         Zero = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom);
         sb.push_back(expect_cycle(op, f, k, Zero));
         @(posedge clk); #1;
      end
      if (hlt) do_reset(2);
   endtask

   always begin
      cv_t act, exp_v;
      @(negedge clk);
      if (mon_en) begin
         act = cv_t'({AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl, illegal, halted});
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t got %h required an expected entry", $time, act);
         end else begin
            exp_v = sb.pop_front();
            if (act !== exp_v) begin
               n_fail++;
               $display("FAIL ctrl_word t=%0t got %h required %h", $time, act, exp_v);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   localparam int ND = 15;
   logic [3:0] d_op [ND] = '{4'd0, 4'd8, 4'd4, 4'd4, 4'd3, 4'd8, 4'd1, 4'd2,
                             4'd12, 4'd13, 4'd14, 4'd8, 4'd8, 4'd8, 4'd15};
   logic [8:0] d_fn [ND] = '{9'h005, 9'h001, 9'h000, 9'h000, 9'h000, 9'h00C, 9'h010, 9'h123,
                             9'h1FF, 9'h001, 9'h0F0, 9'h040, 9'h080, 9'h100, 9'h000};
   int         d_zm [ND] = '{0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   initial begin
      logic [3:0] legal_ops [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd12, 4'd13, 4'd14, 4'd15};
      logic [3:0] op;
      logic [8:0] f;
      reset = 1'b0; Op = '0; Func = '0; Zero = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      do_reset(3);
      for (int i = 0; i < ND; i++) run_instr(d_op[i], d_fn[i], d_zm[i], 1'b0, 10);
      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 8)] : 4'($urandom);
         f  = ($urandom_range(0, 3) != 0) ? 9'(1 << $urandom_range(0, 8)) : 9'($urandom);
         run_instr(op, f, 0, 1'b1, $urandom_range(3, 10));
      end
      mon_en = 1'b0;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d leftover entries required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
